ss_cal_mean_param: RTL and testbench

- Parametrised successor to the single-width sum stage in the SS mean-calculation path.
- Accumulates a run-time-selectable number of samples (2^len, up to 2^MAX_LEN_LOG2), in unsigned or signed mode.
- Produces the full-width sum and a rounded mean by arithmetic shift, with a request/valid sample handshake and an output-enable release.
- Sits between the sample source (buffer/memory reader) and the downstream statistics stage.

---
 rtl/ss_cal_mean_param.sv | 149 ++++++++++++++
 tb/tb_ss_cal_mean_param.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ss_cal_mean_param.sv
// rtl/ss_cal_mean_param.sv - accumulates 2^len samples, emits the full sum and the rounded mean
module ss_cal_mean_param #(
    parameter int SIZE_DATA    = 8,
    parameter int MAX_LEN_LOG2 = 4,
    parameter int LEN_W        = $clog2(MAX_LEN_LOG2 + 1)
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_start_cal_sum,
    input  logic [LEN_W-1:0]                i_len_log2,
    input  logic                            i_signed,
    input  logic                            i_en_cal_sum,
    input  logic [SIZE_DATA-1:0]            i_data,
    input  logic                            i_en_out_sum,
    output logic                            o_en_next_value,
    output logic [SIZE_DATA+MAX_LEN_LOG2-1:0] o_sum,
    output logic [SIZE_DATA-1:0]            o_mean,
    output logic                            o_busy,
    output logic                            o_done
);

    localparam int ACC_W = SIZE_DATA + MAX_LEN_LOG2;
    localparam int CNT_W = MAX_LEN_LOG2 + 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ACC      = 3'd1;
    localparam logic [2:0] S_CALC     = 3'd2;
    localparam logic [2:0] S_WAIT_OUT = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic                 sgn_q, sgn_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [SIZE_DATA-1:0] mean_int_q, mean_int_d;
    logic [ACC_W-1:0]     sum_q, sum_d;
    logic [SIZE_DATA-1:0] mean_q, mean_d;

    logic [LEN_W-1:0]     len_clamped;
    logic [ACC_W-1:0]     data_ext;
    logic [CNT_W-1:0]     cnt_inc;
    logic [CNT_W-1:0]     n_target;
    logic [ACC_W:0]       rnd;
    logic [ACC_W:0]       rsum;
    logic signed [ACC_W:0] shr_s;
    logic [ACC_W:0]       shr_u;
    logic                 take_sample;

    assign o_en_next_value = (state_q == S_ACC);
    assign o_busy          = (state_q != S_IDLE);
    assign o_done          = (state_q == S_DONE);
    assign o_sum           = sum_q;
    assign o_mean          = mean_q;

    assign take_sample = o_en_next_value && i_en_cal_sum;

    always_comb begin
        len_clamped = i_len_log2;
        if (i_len_log2 > LEN_W'(MAX_LEN_LOG2)) begin
            len_clamped = LEN_W'(MAX_LEN_LOG2);
        end
        data_ext = sgn_q ? {{MAX_LEN_LOG2{i_data[SIZE_DATA-1]}}, i_data}
                         : {{MAX_LEN_LOG2{1'b0}}, i_data};
        cnt_inc  = cnt_q + CNT_W'(1);
        n_target = CNT_W'(1) << len_q;
    end

    // One guard bit above the accumulator keeps acc+rnd exact in both modes;
    // the signed and unsigned shifts are kept apart so each keeps its own signedness.
    always_comb begin
        rnd = '0;
        if (len_q != '0) begin
            rnd = (ACC_W + 1)'(1) << (len_q - LEN_W'(1));
        end
        rsum  = {sgn_q & acc_q[ACC_W-1], acc_q} + rnd;
        shr_s = $signed(rsum) >>> len_q;
        shr_u = rsum >> len_q;
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        sgn_d      = sgn_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        mean_int_d = mean_int_q;
        sum_d      = sum_q;
        mean_d     = mean_q;

        // A start from any state begins a fresh run; a pending result is dropped.
        if (i_start_cal_sum) begin
            len_d   = len_clamped;
            sgn_d   = i_signed;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_ACC;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_IDLE;
                S_ACC: begin
                    if (take_sample) begin
                        acc_d = acc_q + data_ext;
                        cnt_d = cnt_inc;
                        if (cnt_inc == n_target) begin
                            state_d = S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    mean_int_d = sgn_q ? SIZE_DATA'(shr_s) : SIZE_DATA'(shr_u);
                    state_d    = S_WAIT_OUT;
                end
                S_WAIT_OUT: begin
                    if (i_en_out_sum) begin
                        sum_d   = acc_q;
                        mean_d  = mean_int_q;
                        state_d = S_DONE;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            sgn_q      <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
            mean_int_q <= '0;
            sum_q      <= '0;
            mean_q     <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            sgn_q      <= sgn_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            mean_int_q <= mean_int_d;
            sum_q      <= sum_d;
            mean_q     <= mean_d;
        end
    end

endmodule

// File: tb/tb_ss_cal_mean_param.sv
// tb/tb_ss_cal_mean_param.sv - directed and randomized runs against an arithmetic mean model
module tb_ss_cal_mean_param;

    localparam int SD = 8;
    localparam int ML = 4;
    localparam int LW = 3;
    localparam int AW = SD + ML;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [LW-1:0] len;
    logic          sgn;
    logic          en_cal;
    logic [SD-1:0] data;
    logic          en_out;
    logic          req;
    logic [AW-1:0] sum;
    logic [SD-1:0] mean;
    logic          busy;
    logic          done;

    int n_cmp = 0;
    int n_bad = 0;

    logic [SD-1:0] smp [16];
    logic [AW-1:0] last_sum;

    always #5 clk = ~clk;

    ss_cal_mean_param #(.SIZE_DATA(SD), .MAX_LEN_LOG2(ML)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_start_cal_sum(start),
        .i_len_log2     (len),
        .i_signed       (sgn),
        .i_en_cal_sum   (en_cal),
        .i_data         (data),
        .i_en_out_sum   (en_out),
        .o_en_next_value(req),
        .o_sum          (sum),
        .o_mean         (mean),
        .o_busy         (busy),
        .o_done         (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Mean = floor((sum + N/2) / N) on plain integers, with N = 2^len.
    task automatic model(input int le, input bit s, output logic [AW-1:0] es, output logic [SD-1:0] em);
        int acc;
        int n;
        int rnd;
        acc = 0;
        n   = 1 << le;
        for (int i = 0; i < n; i++) begin
            acc += s ? int'($signed(smp[i])) : int'(smp[i]);
        end
        rnd = (le > 0) ? (n / 2) : 0;
        es  = AW'(acc);
        em  = SD'((acc + rnd) >>> le);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 16; i++) smp[i] = SD'($urandom);
    endtask

    task automatic begin_run(input int len_in, input bit s, input bit from_idle, input string tag);
        start  = 1'b1;
        len    = LW'(len_in);
        sgn    = s;
        en_cal = 1'b1;
        data   = SD'($urandom);
        en_out = 1'b0;
        if (from_idle) check({tag, "_idle_req"}, req, 0);
        @(negedge clk);
        start  = 1'b0;
        en_cal = 1'b0;
    endtask

    task automatic feed(input int n, input bit gapped, input string tag);
        for (int i = 0; i < n; i++) begin
            en_cal = 1'b1;
            data   = smp[i];
            check({tag, "_acc_req"}, req, 1);
            check({tag, "_acc_done"}, done, 0);
            @(negedge clk);
            if (gapped && i < n - 1) begin
                en_cal = 1'b0;
                data   = SD'($urandom);
                check({tag, "_gap_req"}, req, 1);
                @(negedge clk);
            end
        end
        en_cal = 1'b0;
    endtask

    task automatic finish_run(input int len_in, input bit s, input int delay, input string tag);
        logic [AW-1:0] es;
        logic [SD-1:0] em;
        int le;
        le = (len_in > ML) ? ML : len_in;
        model(le, s, es, em);
        check({tag, "_calc_req"}, req, 0);
        check({tag, "_calc_busy"}, busy, 1);
        check({tag, "_calc_done"}, done, 0);
        en_out = (delay == 0);
        @(negedge clk);
        for (int d = 0; d < delay; d++) begin
            check({tag, "_wait_done"}, done, 0);
            check({tag, "_wait_sum"}, sum, last_sum);
            @(negedge clk);
        end
        en_out = 1'b1;
        @(negedge clk);
        en_out = 1'b0;
        check({tag, "_done"}, done, 1);
        check({tag, "_sum"}, sum, es);
        check({tag, "_mean"}, mean, em);
        @(negedge clk);
        check({tag, "_post_done"}, done, 0);
        check({tag, "_post_busy"}, busy, 0);
        check({tag, "_post_sum"}, sum, es);
        last_sum = es;
    endtask

    task automatic do_run(input int len_in, input bit s, input bit gapped, input int delay, input string tag);
        int le;
        le = (len_in > ML) ? ML : len_in;
        begin_run(len_in, s, 1'b1, tag);
        feed(1 << le, gapped, tag);
        finish_run(len_in, s, delay, tag);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; len = '0; sgn = 1'b0;
        en_cal = 1'b0; data = '0; en_out = 1'b0; last_sum = '0;
        @(negedge clk);
        check("rst_sum", sum, 0);
        check("rst_mean", mean, 0);
        check("rst_busy", busy, 0);
        check("rst_req", req, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        smp[0] = 8'd10; smp[1] = 8'd20; smp[2] = 8'd30; smp[3] = 8'd41;
        do_run(2, 1'b0, 1'b0, 0, "t1");
        check("t1_sum_const", sum, 101);
        check("t1_mean_const", mean, 25);

        smp[0] = 8'hFD; smp[1] = 8'hFC;
        do_run(1, 1'b1, 1'b0, 0, "t2");
        check("t2_sum_const", sum, 12'hFF9);
        check("t2_mean_const", mean, 8'hFD);

        smp[0] = 8'd200;
        do_run(0, 1'b0, 1'b0, 0, "t3");
        check("t3_mean_const", mean, 200);

        for (int i = 0; i < 16; i++) smp[i] = 8'd255;
        do_run(7, 1'b0, 1'b0, 0, "t4");
        check("t4_sum_const", sum, 4080);
        check("t4_mean_const", mean, 255);

        smp[0] = 8'd10; smp[1] = 8'd20; smp[2] = 8'd30; smp[3] = 8'd41;
        do_run(2, 1'b0, 1'b1, 5, "t5");
        check("t5_sum_const", sum, 101);
        check("t5_mean_const", mean, 25);

        fill_random();
        begin_run(2, 1'b0, 1'b1, "t6a");
        feed(2, 1'b0, "t6a");
        fill_random();
        begin_run(2, 1'b0, 1'b0, "t6b");
        feed(4, 1'b0, "t6b");
        finish_run(2, 1'b0, 0, "t6b");

        fill_random();
        begin_run(3, 1'b1, 1'b1, "t7");
        feed(3, 1'b0, "t7");
        #2 rst_n = 1'b0;
        #1;
        check("t7_rst_sum", sum, 0);
        check("t7_rst_mean", mean, 0);
        check("t7_rst_busy", busy, 0);
        check("t7_rst_req", req, 0);
        check("t7_rst_done", done, 0);
        last_sum = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fill_random();
        do_run(3, 1'b1, 1'b0, 0, "t7r");

        for (int r = 0; r < 10; r++) begin
            fill_random();
            do_run(int'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
